operand_sequencer: RTL
======================

# operand_sequencer

Sequential front end for the board's 4-bit ripple adder. It debounces a raw push button and steps through a load sequence: operand A from the switches, then operand B and carry-in. It presents both operands to the adder for one execute cycle and registers the {cout, sum} result for display on the green LEDs. The adder sits directly downstream on op_a/op_b/op_cin and returns its combinational sum/cout to this block.

## Interface
Parameters:
- WIDTH, 4, operand width; must match the downstream adder.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); minimum 2.

Ports:
- CLOCK_50  in  1  system clock; all state is on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- KEY_N  in  1  raw push button, active-low, asynchronous to CLOCK_50, bouncy.
- SW_DATA  in  WIDTH  operand switches.
- SW_CIN  in  1  carry-in switch.
- op_a  out  WIDTH  registered operand A to the adder.
- op_b  out  WIDTH  registered operand B to the adder.
- op_cin  out  1  registered carry-in to the adder.
- op_valid  out  1  high only during the EXEC cycle.
- sum  in  WIDTH  adder sum, combinational from op_a/op_b/op_cin.
- cout  in  1  adder carry-out.
- result  out  WIDTH+1  registered {cout, sum}.
- result_valid  out  1  high while result holds a completed addition.
- state  out  2  current FSM state, for LEDR display.

## Operation
- Synchroniser: KEY_N passes through 2 flops. Reset value is 1 (released).
- Debounce:
  - A counter of width clog2(DEBOUNCE_CYCLES) clears whenever the synced level equals the debounced level.
  - While the two levels differ, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synced level and the counter clears.
  - Debounced level resets to 1.
- press: a registered one-cycle pulse, asserted the cycle after the debounced level goes 1->0. There is no event on release. A held button yields exactly one press.
- FSM (state encoding in parentheses):
  - LOAD_A (00): on press, op_a <= SW_DATA; go to LOAD_B.
  - LOAD_B (01): on press, op_b <= SW_DATA and op_cin <= SW_CIN; go to EXEC.
  - EXEC (10): op_valid=1 for exactly one cycle. At the end of the cycle, result <= {cout, sum} and result_valid <= 1; go to SHOW unconditionally. A press coinciding with EXEC is discarded.
  - SHOW (11): hold all outputs. On press, result <= 0, result_valid <= 0, op_a/op_b/op_cin <= 0; go to LOAD_A.
- Switches are sampled only in the cycle press is high. Switch changes at other times have no effect.
- Width rule: result is exactly WIDTH+1 bits, with cout as the MSB. No truncation and no sign handling.
- Reset (RESET_N low, any time, including mid-debounce or mid-sequence):
  - Immediately: state=LOAD_A, and op_a, op_b, op_cin, op_valid, result, result_valid all 0.
  - Debounce counter 0; synchroniser and debounced level 1.
  - Operation resumes on the first clock after release.

## Timing
- Press latency: if KEY_N falls and stays low, press is asserted 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the first edge that samples the low level. The state update follows on the next edge.
- Glitches: a low or high glitch shorter than DEBOUNCE_CYCLES cycles produces no press.
- EXEC to result: result_valid rises on the edge that ends EXEC, one cycle after op_valid rises. op_a/op_b/op_cin are stable throughout EXEC.
- Press spacing: consecutive presses are at least 2·DEBOUNCE_CYCLES cycles apart (press then release must both settle).
- Output stability: all outputs are registered with no combinational path from inputs to outputs. sum/cout are sampled only in EXEC.

## Test plan
Sim uses DEBOUNCE_CYCLES=4 and a behavioural adder model.
- Reset: hold RESET_N=0 for 3 cycles with KEY_N=0 -> all outputs 0, state=00; no press after release until KEY_N goes high and then low again.
- Full add: SW_DATA=9 then press; SW_DATA=8, SW_CIN=1 then press -> one op_valid cycle with op_a=9, op_b=8, op_cin=1; next cycle result=5'h12, result_valid=1, state=11.
- Bounce rejection: in LOAD_A, KEY_N toggles low 3 cycles / high 2 cycles for 40 cycles, then stays high -> no press, state stays 00, op_a=0.
- Held button: KEY_N low for 200 cycles in LOAD_A -> exactly one press; state=01; SW_DATA changes during the hold are ignored.
- Async reset mid-sequence: load A=0xF, be in LOAD_B, drop RESET_N between clock edges -> op_a=0 and state=00 before the next edge.
- Clear: press in SHOW with result=5'h12 -> result=0, result_valid=0, state=00; a new sequence with A=0xF, B=0x1, cin=0 gives result=5'h10.

Source files
------------

// File: rtl/operand_sequencer.sv
// Button-stepped operand loader for the downstream ripple adder: debounces KEY_N,
// loads A then B/cin from the switches, runs one EXEC cycle and holds {cout, sum}.
module operand_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             KEY_N,
  input  logic [WIDTH-1:0] SW_DATA,
  input  logic             SW_CIN,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_cin,
  output logic             op_valid,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic [1:0]       state
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             key_p0;
  logic             key_p1;
  logic             vld_p0;
  logic             vld_p1;
  logic [CNT_W-1:0] db_cnt;
  logic             db_lvl;
  logic             db_lvl_p1;
  logic             armed;
  logic             press;
  logic             load_a;
  logic             load_b;
  logic             capture;
  logic             clear;

  // Stage p0/p1: two-flop synchroniser; vld_pN marks when it holds real samples
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      key_p0 <= KEY_N;
      key_p1 <= key_p0;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
    end
  end

  // Debounce: level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  // A press needs a genuinely observed release first, so a button held through reset
  // cannot produce a phantom press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      db_cnt    <= '0;
      db_lvl    <= 1'b1;
      db_lvl_p1 <= 1'b1;
      armed     <= 1'b0;
      press     <= 1'b0;
    end else begin
      db_lvl_p1 <= db_lvl;
      press     <= armed & db_lvl_p1 & ~db_lvl;
      if (vld_p1 && key_p1 && db_lvl)
        armed <= 1'b1;
      if (key_p1 == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_MAX) begin
        db_lvl <= key_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    capture = 1'b0;
    clear   = 1'b0;
    case (state_q)
      LOAD_A: if (press) begin
        load_a  = 1'b1;
        state_d = LOAD_B;
      end
      LOAD_B: if (press) begin
        load_b  = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_d = SHOW;
      end
      SHOW: if (press) begin
        clear   = 1'b1;
        state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
  end

  // Stage p2: operand/result registers follow the FSM decode
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= LOAD_A;
      op_a         <= '0;
      op_b         <= '0;
      op_cin       <= 1'b0;
      op_valid     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_valid <= (state_d == EXEC);
      if (load_a)
        op_a <= SW_DATA;
      if (load_b) begin
        op_b   <= SW_DATA;
        op_cin <= SW_CIN;
      end
      if (capture) begin
        result       <= {cout, sum};
        result_valid <= 1'b1;
      end
      if (clear) begin
        op_a         <= '0;
        op_b         <= '0;
        op_cin       <= 1'b0;
        result       <= '0;
        result_valid <= 1'b0;
      end
    end
  end

  assign state = state_q;

endmodule
